mac_rx_frame_filter: RTL and testbench

Receive-side Ethernet frame filter on the 64-bit MAC AXI-Stream path, sitting directly upstream of the UDT client's `mac_rx_axis_*` input in the `clk156` domain. It inspects each frame's destination MAC and EtherType and forwards only frames addressed to this node (unicast or broadcast) carrying an accepted EtherType. All other frames, and runts, are discarded. Decisions are made after the second beat using a 2-entry holding FIFO, so accepted frames leave byte-identical.

---
 rtl/mac_rx_filter_pkg.sv | 22 ++
 rtl/axis_fifo2.sv | 81 ++++++++
 rtl/mac_rx_frame_filter.sv | 166 ++++++++++++++++
 tb/tb_mac_rx_frame_filter.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_rx_filter_pkg.sv
// Shared types and constants for the MAC RX frame filter.
// Build option: MAC_RX_FILTER_STATS_EN enables the statistics counters.
package mac_rx_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_PASS,
    ST_DROP
  } state_t;

  localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

  // EtherType lives in wire bytes 12/13, i.e. lanes 4/5 of beat 1
  localparam int ETYPE_HI_BYTE = 4;
  localparam int ETYPE_LO_BYTE = 5;

  function automatic logic [15:0] beat1_etype(input logic [63:0] d);
    return {d[ETYPE_HI_BYTE*8 +: 8], d[ETYPE_LO_BYTE*8 +: 8]};
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry AXI-Stream register FIFO (data/keep/last).
// Entry 0 is always the head; flush empties it in one cycle.
module axis_fifo2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_keep,
  input  logic        in_last,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_last,
  output logic [1:0]  count
);

  logic [63:0] d0, d1;
  logic [7:0]  k0, k1;
  logic        l0, l1;
  logic        pop_ok;
  logic        push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0    <= '0;
      d1    <= '0;
      k0    <= '0;
      k1    <= '0;
      l0    <= 1'b0;
      l1    <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            d0 <= in_data;
            k0 <= in_keep;
            l0 <= in_last;
          end else begin
            d1 <= in_data;
            k1 <= in_keep;
            l1 <= in_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          d0    <= d1;
          k0    <= k1;
          l0    <= l1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            d0 <= in_data;
            k0 <= in_keep;
            l0 <= in_last;
          end else begin
            d0 <= d1;
            k0 <= k1;
            l0 <= l1;
            d1 <= in_data;
            k1 <= in_keep;
            l1 <= in_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = d0;
  assign out_keep = k0;
  assign out_last = l0;

endmodule

// File: rtl/mac_rx_frame_filter.sv
// RX frame filter: forwards unicast/broadcast frames with accepted EtherType.
// Build option: MAC_RX_FILTER_STATS_EN implements pass/drop counters.
module mac_rx_frame_filter #(
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [15:0] ETYPE_A      = 16'h0800,
  parameter logic [15:0] ETYPE_B      = 16'h0806,
  parameter int          CNT_W        = 32
) (
  input  logic             clk156,
  input  logic             areset,
  input  logic [47:0]      cfg_local_mac,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [7:0]       s_axis_tkeep,
  input  logic [63:0]      s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [7:0]       m_axis_tkeep,
  output logic [63:0]      m_axis_tdata,
  output logic [CNT_W-1:0] stat_pass_cnt,
  output logic [CNT_W-1:0] stat_drop_cnt
);

  import mac_rx_filter_pkg::*;

  state_t      state_q, state_d;
  logic [1:0]  fifo_cnt;
  logic        fifo_empty;
  logic        rdy_c;
  logic        hs_c;
  logic        s_hs;
  logic        push;
  logic        pop;
  logic        flush;
  logic        pass_evt;
  logic        drop_evt;
  logic        dst_hit_now;
  logic        dst_hit_q;
  logic [15:0] etype;
  logic        frame_ok;

  assign fifo_empty    = (fifo_cnt == 2'd0);
  assign s_axis_tready = rdy_c & ~areset;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign dst_hit_now = (s_axis_tdata[47:0] == cfg_local_mac) ||
                       (ACCEPT_BCAST && (s_axis_tdata[47:0] == BCAST_MAC));
  assign etype    = beat1_etype(s_axis_tdata);
  assign frame_ok = dst_hit_q && ((etype == ETYPE_A) || (etype == ETYPE_B));

  // destination match is latched with beat 0, judged with beat 1
  always_ff @(posedge clk156 or posedge areset) begin
    if (areset) begin
      dst_hit_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && s_hs) begin
      dst_hit_q <= dst_hit_now;
    end
  end

  always_ff @(posedge clk156 or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_hs && !s_axis_tlast) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (s_hs) begin
          if (s_axis_tlast) state_d = ST_IDLE;
          else if (frame_ok) state_d = ST_PASS;
          else state_d = ST_DROP;
        end
      end
      ST_PASS, ST_DROP: begin
        if (s_hs && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy_c    = 1'b0;
    hs_c     = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    pass_evt = 1'b0;
    drop_evt = 1'b0;
    unique case (state_q)
      ST_IDLE: rdy_c = fifo_empty;
      ST_HOLD: rdy_c = 1'b1;
      ST_PASS: rdy_c = ~fifo_cnt[1];
      ST_DROP: rdy_c = 1'b1;
      default: rdy_c = 1'b0;
    endcase
    hs_c = s_axis_tvalid & rdy_c;
    unique case (state_q)
      ST_IDLE: begin
        if (hs_c && s_axis_tlast) drop_evt = 1'b1;
        else if (hs_c) push = 1'b1;
      end
      ST_HOLD: begin
        if (hs_c && frame_ok) begin
          push     = 1'b1;
          pass_evt = 1'b1;
        end else if (hs_c) begin
          flush    = 1'b1;
          drop_evt = 1'b1;
        end
      end
      ST_PASS: push = hs_c;
      default: ;
    endcase
    m_axis_tvalid = ~fifo_empty & (state_q != ST_HOLD);
  end

  axis_fifo2 u_fifo (
    .clk      (clk156),
    .rst      (areset),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .in_data  (s_axis_tdata),
    .in_keep  (s_axis_tkeep),
    .in_last  (s_axis_tlast),
    .out_data (m_axis_tdata),
    .out_keep (m_axis_tkeep),
    .out_last (m_axis_tlast),
    .count    (fifo_cnt)
  );

`ifdef MAC_RX_FILTER_STATS_EN
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] drop_cnt;

  // saturating: a stuck-at-max counter beats a wrapped one
  always_ff @(posedge clk156 or posedge areset) begin
    if (areset) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pass_evt && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
      if (drop_evt && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign stat_pass_cnt = pass_cnt;
  assign stat_drop_cnt = drop_cnt;
`else
  logic unused_evt;

  assign unused_evt    = pass_evt ^ drop_evt;
  assign stat_pass_cnt = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_rx_frame_filter.sv
// Self-checking bench for mac_rx_frame_filter with a frame-level model.
// A second instance with broadcast disabled shadows the same input traffic.
module tb_mac_rx_frame_filter;

`ifdef MAC_RX_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk156 = 1'b0;
  logic        areset;
  logic [47:0] cfg_local_mac;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tkeep;
  logic [63:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tkeep;
  logic [63:0] m_axis_tdata;
  logic [31:0] stat_pass_cnt;
  logic [31:0] stat_drop_cnt;

  logic        b_s_tvalid;
  logic        b_s_tready;
  logic        b_m_tvalid;
  logic        b_m_tlast;
  logic [7:0]  b_m_tkeep;
  logic [63:0] b_m_tdata;
  logic [31:0] b_pass;
  logic [31:0] b_drop;

  assign b_s_tvalid = s_axis_tvalid & s_axis_tready;

  always #5 clk156 = ~clk156;

  mac_rx_frame_filter u_dut (
    .clk156        (clk156),
    .areset        (areset),
    .cfg_local_mac (cfg_local_mac),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tdata  (m_axis_tdata),
    .stat_pass_cnt (stat_pass_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  mac_rx_frame_filter #(.ACCEPT_BCAST(1'b0)) u_dut_nb (
    .clk156        (clk156),
    .areset        (areset),
    .cfg_local_mac (cfg_local_mac),
    .s_axis_tvalid (b_s_tvalid),
    .s_axis_tready (b_s_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (b_m_tvalid),
    .m_axis_tready (1'b1),
    .m_axis_tlast  (b_m_tlast),
    .m_axis_tkeep  (b_m_tkeep),
    .m_axis_tdata  (b_m_tdata),
    .stat_pass_cnt (b_pass),
    .stat_drop_cnt (b_drop)
  );

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];
  beat_t exp_b[$];
  logic [7:0] fr[128];
  int    fr_len;
  beat_t bt[16];
  int    nb;
  int    pass_n = 0;
  int    drop_n = 0;
  int    rdy_mode = 0;
  int    stall_cnt;
  bit    hold_v = 1'b0;
  beat_t hold_b;

  // sink ready pattern: 0 always, 1 toggling, 2 random
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk156);
      #1;
      case (rdy_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor samples mid-cycle; a transfer seen here completes at next edge
  always @(negedge clk156) begin
    beat_t cur;
    beat_t e;
    if (areset) begin
      hold_v = 1'b0;
    end else begin
      cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (hold_v && m_axis_tvalid) begin
        total++;
        if (cur !== hold_b) begin
          bad++;
          $display("FAIL stable: got=%h want=%h", cur, hold_b);
        end
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_b = cur;
      if (m_axis_tvalid && m_axis_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got=%h want=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL out_beat: got=%h want=%h", cur, e);
          end
        end
      end
      if (b_m_tvalid) begin
        cur = {b_m_tdata, b_m_tkeep, b_m_tlast};
        total++;
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL nb_unexpected_beat: got=%h want=none", cur);
        end else begin
          e = exp_b.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL nb_out_beat: got=%h want=%h", cur, e);
          end
        end
      end
    end
  end

  task automatic build_frame(input int len, input logic [47:0] dst,
                             input logic [15:0] et);
    fr_len = len;
    for (int i = 0; i < 128; i++) fr[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) fr[i] = dst[8*i +: 8];
    fr[12] = et[15:8];
    fr[13] = et[7:0];
  endtask

  function automatic bit model_pass(input bit bcast_en);
    bit loc = 1'b1;
    bit bc = 1'b1;
    logic [47:0] lm = cfg_local_mac;
    logic [15:0] et;
    if (fr_len <= 8) return 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (fr[i] != lm[8*i +: 8]) loc = 1'b0;
      if (fr[i] != 8'hff) bc = 1'b0;
    end
    et = {fr[12], fr[13]};
    return (loc || (bcast_en && bc)) && (et == 16'h0800 || et == 16'h0806);
  endfunction

  task automatic send_frame(input int abort_at);
    bit pa = model_pass(1'b1);
    bit pb = model_pass(1'b0);
    bit rdy;
    int n;
    nb = (fr_len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++) begin
        bt[b].d[8*j +: 8] = fr[8*b + j];
        bt[b].k[j] = ((8*b + j) < fr_len);
      end
      bt[b].l = (b == nb - 1);
    end
    for (int b = 0; b < nb; b++) begin
      if (pa) exp_q.push_back(bt[b]);
      if (pb) exp_b.push_back(bt[b]);
    end
    if (pa) pass_n++;
    else drop_n++;
    stall_cnt = 0;
    for (int b = 0; b < nb; b++) begin
      if (b == abort_at) begin
        s_axis_tvalid = 1'b0;
        return;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = bt[b].d;
      s_axis_tkeep  = bt[b].k;
      s_axis_tlast  = bt[b].l;
      n = 0;
      do begin
        @(negedge clk156);
        rdy = s_axis_tready;
        @(posedge clk156);
        #1;
        n++;
        if (!rdy) stall_cnt++;
      end while (!rdy && n < 500);
      if (!rdy) begin
        total++;
        bad++;
        $display("FAIL in_timeout: beat=%0d waited=%0d want=ready", b, n);
        s_axis_tvalid = 1'b0;
        return;
      end
      if (b == 0) begin
        total++;
        if (m_axis_tvalid !== 1'b0) begin
          bad++;
          $display("FAIL hold_valid: got=%b want=0", m_axis_tvalid);
        end
      end
      if (b == 1) begin
        total++;
        if (m_axis_tvalid !== pa) begin
          bad++;
          $display("FAIL decide_valid: got=%b want=%b", m_axis_tvalid, pa);
        end
        if (pa) begin
          total++;
          if (m_axis_tdata !== bt[0].d) begin
            bad++;
            $display("FAIL first_beat: got=%h want=%h", m_axis_tdata, bt[0].d);
          end
        end
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((exp_q.size() != 0 || exp_b.size() != 0) && n < 400) begin
      @(posedge clk156);
      n++;
    end
    repeat (3) @(posedge clk156);
    #1;
    ok = (exp_q.size() == 0) && (exp_b.size() == 0);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge clk156);
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata,
         s_axis_tready} !== '0) begin
      bad++;
      $display("FAIL reset_out: got=%b/%h/%h ready=%b want=0",
               m_axis_tvalid, m_axis_tkeep, m_axis_tdata, s_axis_tready);
    end
    areset = 1'b0;
    #1;
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got=%b want=1", s_axis_tready);
    end
    total++;
    if ({stat_pass_cnt, stat_drop_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_cnt: got=%0d/%0d want=0/0",
               stat_pass_cnt, stat_drop_cnt);
    end
  endtask

  task automatic test_ipv4();
    bit ok;
    rdy_mode = 0;
    build_frame(64, cfg_local_mac, 16'h0800);
    send_frame(-1);
    drain(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL ipv4_drain: got=%0d beats left want=0", exp_q.size());
    end
    total++;
    if (stat_pass_cnt !== (STATS ? 32'(pass_n) : 32'd0)) begin
      bad++;
      $display("FAIL ipv4_pass_cnt: got=%0d want=%0d", stat_pass_cnt, pass_n);
    end
  endtask

  task automatic test_wrong_dst();
    bit ok;
    build_frame(64, 48'h99_00_00_00_00_02, 16'h0800);
    send_frame(-1);
    total++;
    if (stall_cnt !== 0) begin
      bad++;
      $display("FAIL drop_ready: got=%0d stalls want=0", stall_cnt);
    end
    drain(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL drop_drain: got=%0d left want=0", exp_q.size());
    end
    total++;
    if (stat_drop_cnt !== (STATS ? 32'(drop_n) : 32'd0)) begin
      bad++;
      $display("FAIL drop_cnt: got=%0d want=%0d", stat_drop_cnt, drop_n);
    end
  endtask

  task automatic test_bcast_arp();
    bit ok;
    build_frame(60, 48'hffff_ffff_ffff, 16'h0806);
    send_frame(-1);
    drain(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL bcast_drain: got=%0d/%0d left want=0",
               exp_q.size(), exp_b.size());
    end
    total++;
    if (b_pass !== (STATS ? 32'd1 : 32'd0)) begin
      bad++;
      $display("FAIL nb_pass_cnt: got=%0d want=1", b_pass);
    end
  endtask

  task automatic test_runt();
    bit ok;
    build_frame(8, cfg_local_mac, 16'h0800);
    send_frame(-1);
    repeat (2) @(posedge clk156);
    #1;
    total++;
    if (stat_drop_cnt !== (STATS ? 32'(drop_n) : 32'd0)) begin
      bad++;
      $display("FAIL runt_cnt: got=%0d want=%0d", stat_drop_cnt, drop_n);
    end
    build_frame(64, cfg_local_mac, 16'h0800);
    send_frame(-1);
    drain(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL runt_next: got=%0d left want=0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rdy_mode = 1;
    build_frame(64, cfg_local_mac, 16'h0800);
    send_frame(-1);
    drain(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL bp_drain: got=%0d left want=0", exp_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [47:0] dst;
    logic [15:0] et;
    int len;
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8)
                                        : $urandom_range(14, 128);
      case ($urandom_range(0, 3))
        0: dst = cfg_local_mac;
        1: dst = 48'hffff_ffff_ffff;
        2: dst = {16'($urandom), 32'($urandom)};
        default: dst = cfg_local_mac ^ (48'h1 << (8 * $urandom_range(0, 5)));
      endcase
      case ($urandom_range(0, 3))
        0: et = 16'h0800;
        1: et = 16'h0806;
        2: et = 16'($urandom);
        default: et = 16'h0008;
      endcase
      build_frame(len, dst, et);
      send_frame(-1);
      repeat ($urandom_range(0, 3)) @(posedge clk156);
      #1;
    end
    drain(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL rand_drain: got=%0d/%0d left want=0",
               exp_q.size(), exp_b.size());
    end
    total++;
    if ({stat_pass_cnt, stat_drop_cnt} !==
        (STATS ? {32'(pass_n), 32'(drop_n)} : 64'd0)) begin
      bad++;
      $display("FAIL rand_cnt: got=%0d/%0d want=%0d/%0d",
               stat_pass_cnt, stat_drop_cnt, pass_n, drop_n);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rdy_mode = 0;
    build_frame(64, cfg_local_mac, 16'h0800);
    send_frame(3);
    areset = 1'b1;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata,
         s_axis_tready} !== '0) begin
      bad++;
      $display("FAIL mid_reset_out: got=%b/%h/%h ready=%b want=0",
               m_axis_tvalid, m_axis_tkeep, m_axis_tdata, s_axis_tready);
    end
    exp_q.delete();
    exp_b.delete();
    pass_n = 0;
    drop_n = 0;
    repeat (2) @(posedge clk156);
    #1;
    areset = 1'b0;
    #1;
    total++;
    if ({stat_pass_cnt, stat_drop_cnt} !== '0) begin
      bad++;
      $display("FAIL mid_reset_cnt: got=%0d/%0d want=0/0",
               stat_pass_cnt, stat_drop_cnt);
    end
    @(posedge clk156);
    #1;
    build_frame(64, cfg_local_mac, 16'h0800);
    send_frame(-1);
    drain(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_next: got=%0d left want=0", exp_q.size());
    end
    total++;
    if (stat_pass_cnt !== (STATS ? 32'd1 : 32'd0)) begin
      bad++;
      $display("FAIL mid_reset_pass: got=%0d want=1", stat_pass_cnt);
    end
  endtask

  initial begin
    areset        = 1'b1;
    cfg_local_mac = 48'h01_00_00_00_00_02;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tdata  = '0;
    test_reset();
    test_ipv4();
    test_wrong_dst();
    test_bcast_arp();
    test_runt();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
